// File: rtl/mvu_pkg.sv
// mvu_pkg: shared state type and width helper for the MVAU input sequencer
package mvu_pkg;
  typedef enum logic {FILL, REUSE} ctrl_state_t;
  function automatic int clog2_min1(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mvu_stream_ctrl_if.sv
// mvu_stream_ctrl_if: activation input stream, PE-side beat stream and weight memory address
interface mvu_stream_ctrl_if #(
  parameter int DW = 2,
  parameter int ABW = 2
);
  logic in_v;
  logic [DW-1:0] in_data;
  logic in_rdy;
  logic [ABW-1:0] wmem_addr;
  logic act_v;
  logic [DW-1:0] act_data;
  logic act_first;
  logic act_last;
  logic act_rdy;
  modport slave (
    input in_v, in_data, act_rdy,
    output in_rdy, wmem_addr, act_v, act_data, act_first, act_last
  );
  modport master (
    output in_v, in_data, act_rdy,
    input in_rdy, wmem_addr, act_v, act_data, act_first, act_last
  );
endinterface

// File: rtl/mvu_act_buffer.sv
// mvu_act_buffer: one-vector activation store, sync write, registered read with enable
module mvu_act_buffer #(
  parameter int DEPTH = 2,
  parameter int DW = 2,
  parameter int AW = 1
) (
  input  logic          clock,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);
  logic [DW-1:0] mem [DEPTH];
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/mvu_stream_ctrl.sv
// mvu_stream_ctrl: captures one activation vector, replays it for every neuron fold in step with weight memory
module mvu_stream_ctrl
  import mvu_pkg::*;
#(
  parameter int MW = 4,
  parameter int MH = 4,
  parameter int SIMD = 2,
  parameter int PE = 2,
  parameter int TI = 1
) (
  input logic clock,
  input logic resetn,
  mvu_stream_ctrl_if.slave s
);
  localparam int SF = MW / SIMD;
  localparam int NF = MH / PE;
  localparam int DEPTH = SF * NF;
  localparam int ABW = clog2_min1(DEPTH);
  localparam int SFW = clog2_min1(SF);
  localparam int NFW = clog2_min1(NF);
  localparam int DW = SIMD * TI;

  if (MW % SIMD != 0) begin : g_mw_chk
    $error("MW must be a multiple of SIMD");
  end
  if (MH % PE != 0) begin : g_mh_chk
    $error("MH must be a multiple of PE");
  end

  ctrl_state_t state, state_nxt;
  logic [SFW-1:0] sf;
  logic [NFW-1:0] nf;
  logic [ABW-1:0] addr, held_addr;
  logic act_v, act_first, act_last, use_buf;
  logic [DW-1:0] fill_data, buf_data;
  logic adv, fire, last_sf, last_nf;

  assign adv = s.act_rdy | ~act_v;
  assign fire = adv & (state == FILL ? s.in_v : 1'b1);
  assign last_sf = sf == SFW'(SF - 1);
  assign last_nf = nf == NFW'(NF - 1);

  // in FILL nf is 0, so last_nf is only true there when there is a single fold
  always_comb state_nxt = fire & last_sf ? (last_nf ? FILL : REUSE) : state;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= FILL;
      sf <= '0;
      nf <= '0;
      addr <= '0;
      held_addr <= '0;
      act_v <= 1'b0;
      act_first <= 1'b0;
      act_last <= 1'b0;
      use_buf <= 1'b0;
      fill_data <= '0;
    end else begin
      state <= state_nxt;
      if (adv) act_v <= fire;
      if (fire) begin
        sf <= last_sf ? '0 : sf + 1'b1;
        if (last_sf) nf <= last_nf ? '0 : nf + 1'b1;
        addr <= addr == ABW'(DEPTH - 1) ? '0 : addr + 1'b1;
        held_addr <= addr;
        act_first <= sf == '0;
        act_last <= last_sf;
        use_buf <= state == REUSE;
        if (state == FILL) fill_data <= s.in_data;
      end
    end
  end

  mvu_act_buffer #(.DEPTH(SF), .DW(DW), .AW(SFW)) u_buf (
    .clock   (clock),
    .wr_en   (fire & (state == FILL)),
    .wr_addr (sf),
    .wr_data (s.in_data),
    .rd_en   (fire & (state == REUSE)),
    .rd_addr (sf),
    .rd_data (buf_data)
  );

  // holding the stalled beat's address keeps the registered weight read stable
  assign s.wmem_addr = adv ? addr : held_addr;
  assign s.in_rdy = resetn & (state == FILL) & adv;
  assign s.act_v = act_v;
  assign s.act_first = act_first;
  assign s.act_last = act_last;
  assign s.act_data = use_buf ? buf_data : fill_data;
endmodule

// File: tb/tb_mvu_stream_ctrl.sv
// tb_mvu_stream_ctrl: directed vector table plus reset and single-fold sequences
module tb_mvu_stream_ctrl;
  logic clock = 1'b0;
  logic resetn = 1'b0;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  mvu_stream_ctrl_if #(.DW(2), .ABW(2)) if0 ();
  mvu_stream_ctrl_if #(.DW(2), .ABW(1)) if1 ();

  mvu_stream_ctrl #(.MW(4), .MH(4), .SIMD(2), .PE(2), .TI(1)) u0 (
    .clock (clock), .resetn (resetn), .s (if0)
  );
  mvu_stream_ctrl #(.MW(2), .MH(2), .SIMD(2), .PE(2), .TI(1)) u1 (
    .clock (clock), .resetn (resetn), .s (if1)
  );

  logic [7:0] w0;
  always_ff @(posedge clock) w0 <= 8'h10 + 8'(if0.wmem_addr);

  typedef struct {
    logic v; logic [1:0] d; logic rdy;
    logic e_rdy; logic [1:0] e_wa;
    logic e_v; logic [1:0] e_d; logic e_f; logic e_l; logic [1:0] e_w;
  } vec_t;

  localparam logic [1:0] A = 2'b10, B = 2'b01, C = 2'b11, D = 2'b00;
  vec_t vecs [20];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  initial begin
    vecs[0]  = '{1'b1, A,    1'b1, 1'b1, 2'd0, 1'b1, A, 1'b1, 1'b0, 2'd0};
    vecs[1]  = '{1'b1, B,    1'b1, 1'b1, 2'd1, 1'b1, B, 1'b0, 1'b1, 2'd1};
    vecs[2]  = '{1'b1, C,    1'b1, 1'b0, 2'd2, 1'b1, A, 1'b1, 1'b0, 2'd2};
    vecs[3]  = '{1'b1, C,    1'b1, 1'b0, 2'd3, 1'b1, B, 1'b0, 1'b1, 2'd3};
    vecs[4]  = '{1'b1, C,    1'b1, 1'b1, 2'd0, 1'b1, C, 1'b1, 1'b0, 2'd0};
    vecs[5]  = '{1'b1, D,    1'b1, 1'b1, 2'd1, 1'b1, D, 1'b0, 1'b1, 2'd1};
    vecs[6]  = '{1'b0, 2'd0, 1'b1, 1'b0, 2'd2, 1'b1, C, 1'b1, 1'b0, 2'd2};
    vecs[7]  = '{1'b0, 2'd0, 1'b0, 1'b0, 2'd2, 1'b1, C, 1'b1, 1'b0, 2'd2};
    vecs[8]  = '{1'b0, 2'd0, 1'b0, 1'b0, 2'd2, 1'b1, C, 1'b1, 1'b0, 2'd2};
    vecs[9]  = '{1'b0, 2'd0, 1'b0, 1'b0, 2'd2, 1'b1, C, 1'b1, 1'b0, 2'd2};
    vecs[10] = '{1'b0, 2'd0, 1'b1, 1'b0, 2'd3, 1'b1, D, 1'b0, 1'b1, 2'd3};
    vecs[11] = '{1'b0, 2'd0, 1'b1, 1'b1, 2'd0, 1'b0, D, 1'b0, 1'b0, 2'd0};
    vecs[12] = '{1'b1, A,    1'b1, 1'b1, 2'd0, 1'b1, A, 1'b1, 1'b0, 2'd0};
    vecs[13] = '{1'b0, 2'd0, 1'b1, 1'b1, 2'd1, 1'b0, D, 1'b0, 1'b0, 2'd0};
    vecs[14] = '{1'b0, 2'd0, 1'b1, 1'b1, 2'd1, 1'b0, D, 1'b0, 1'b0, 2'd0};
    vecs[15] = '{1'b1, B,    1'b1, 1'b1, 2'd1, 1'b1, B, 1'b0, 1'b1, 2'd1};
    vecs[16] = '{1'b0, 2'd0, 1'b1, 1'b0, 2'd2, 1'b1, A, 1'b1, 1'b0, 2'd2};
    vecs[17] = '{1'b0, 2'd0, 1'b1, 1'b0, 2'd3, 1'b1, B, 1'b0, 1'b1, 2'd3};
    vecs[18] = '{1'b1, C,    1'b0, 1'b0, 2'd3, 1'b1, B, 1'b0, 1'b1, 2'd3};
    vecs[19] = '{1'b1, C,    1'b1, 1'b1, 2'd0, 1'b1, C, 1'b1, 1'b0, 2'd0};

    if0.in_v = 1'b0; if0.in_data = '0; if0.act_rdy = 1'b0;
    if1.in_v = 1'b0; if1.in_data = '0; if1.act_rdy = 1'b0;
    #3;
    chk("reset in_rdy", 32'(if0.in_rdy), 32'd0);
    chk("reset act_v", 32'(if0.act_v), 32'd0);
    chk("reset act_data", 32'(if0.act_data), 32'd0);
    chk("reset first/last", 32'({if0.act_first, if0.act_last}), 32'd0);
    chk("reset wmem_addr", 32'(if0.wmem_addr), 32'd0);
    chk("reset nf1 in_rdy", 32'(if1.in_rdy), 32'd0);
    #9 resetn = 1'b1;

    for (int i = 0; i < 20; i++) begin
      if0.in_v = vecs[i].v; if0.in_data = vecs[i].d; if0.act_rdy = vecs[i].rdy;
      #1;
      chk($sformatf("r%0d in_rdy", i), 32'(if0.in_rdy), 32'(vecs[i].e_rdy));
      chk($sformatf("r%0d wmem_addr", i), 32'(if0.wmem_addr), 32'(vecs[i].e_wa));
      @(posedge clock); #1;
      chk($sformatf("r%0d act_v", i), 32'(if0.act_v), 32'(vecs[i].e_v));
      if (vecs[i].e_v) begin
        chk($sformatf("r%0d act_data", i), 32'(if0.act_data), 32'(vecs[i].e_d));
        chk($sformatf("r%0d first/last", i), 32'({if0.act_first, if0.act_last}),
            32'({vecs[i].e_f, vecs[i].e_l}));
        chk($sformatf("r%0d wmem_out", i), 32'(w0), 32'(8'h10 + 8'(vecs[i].e_w)));
      end
    end

    resetn = 1'b0;
    #1;
    chk("midreset act_v", 32'(if0.act_v), 32'd0);
    chk("midreset act_data", 32'(if0.act_data), 32'd0);
    chk("midreset first", 32'(if0.act_first), 32'd0);
    chk("midreset in_rdy", 32'(if0.in_rdy), 32'd0);
    chk("midreset wmem_addr", 32'(if0.wmem_addr), 32'd0);
    @(posedge clock); #1;
    resetn = 1'b1;
    if0.in_v = 1'b1; if0.in_data = A; if0.act_rdy = 1'b1;
    #1;
    chk("postreset in_rdy", 32'(if0.in_rdy), 32'd1);
    chk("postreset wmem_addr", 32'(if0.wmem_addr), 32'd0);
    @(posedge clock); #1;
    if0.in_v = 1'b0;
    chk("postreset act_v", 32'(if0.act_v), 32'd1);
    chk("postreset act_data", 32'(if0.act_data), 32'(A));
    chk("postreset first/last", 32'({if0.act_first, if0.act_last}), 32'b10);

    begin
      logic [5:0] rdy_pat = 6'b101101;
      logic exp_v = 1'b0;
      logic [1:0] exp_d = '0;
      for (int i = 0; i < 6; i++) begin
        logic exp_rdy;
        if1.in_v = 1'b1; if1.in_data = 2'(i + 1); if1.act_rdy = rdy_pat[i];
        exp_rdy = rdy_pat[i] | ~exp_v;
        #1;
        chk($sformatf("nf1 c%0d in_rdy", i), 32'(if1.in_rdy), 32'(exp_rdy));
        chk($sformatf("nf1 c%0d wmem_addr", i), 32'(if1.wmem_addr), 32'd0);
        if (exp_rdy) begin
          exp_v = 1'b1;
          exp_d = 2'(i + 1);
        end
        @(posedge clock); #1;
        chk($sformatf("nf1 c%0d act_v", i), 32'(if1.act_v), 32'(exp_v));
        chk($sformatf("nf1 c%0d act_data", i), 32'(if1.act_data), 32'(exp_d));
        chk($sformatf("nf1 c%0d first/last", i), 32'({if1.act_first, if1.act_last}), 32'b11);
      end
      if1.in_v = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
